// File: rtl/seq_divider_8x4_if.sv
// rtl/seq_divider_8x4_if.sv - start/done handshake and operand/result bundle for seq_divider_8x4
interface seq_divider_8x4_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_8x4.sv
// rtl/seq_divider_8x4.sv - 8/4 restoring divider, one quotient bit per clock
// busy/done are registered one cycle behind the state, giving a 10-cycle divide and a 2-cycle divide-by-zero.
module seq_divider_8x4 (
  input logic             clk,
  input logic             rst_n,
  seq_divider_8x4_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0] state;
  logic [2:0] cnt;
  logic [7:0] shreg;
  logic [3:0] rem;
  logic [3:0] dvsr;
  logic [7:0] quotient_r;
  logic [3:0] remainder_r;
  logic       dbz_r;
  logic       busy_r;
  logic       done_r;

  logic [4:0] pr;
  logic       ge;
  logic [3:0] diff;
  logic [3:0] rem_next;
  logic [7:0] shreg_next;

  // The remainder always fits in 4 bits after a step, so the low 4 bits of the difference suffice.
  always_comb begin
    pr         = {rem, shreg[7]};
    ge         = (pr >= {1'b0, dvsr});
    diff       = pr[3:0] - dvsr;
    rem_next   = ge ? diff : pr[3:0];
    shreg_next = {shreg[6:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      shreg       <= 8'd0;
      rem         <= 4'd0;
      dvsr        <= 4'd0;
      quotient_r  <= 8'd0;
      remainder_r <= 4'd0;
      dbz_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r <= (state == S_RUN);
      done_r <= (state == S_FINISH);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.divisor != 4'd0) begin
              shreg <= bus.dividend;
              dvsr  <= bus.divisor;
              rem   <= 4'd0;
              cnt   <= 3'd0;
              state <= S_RUN;
            end else begin
              quotient_r  <= 8'hFF;
              remainder_r <= 4'hF;
              dbz_r       <= 1'b1;
              state       <= S_FINISH;
            end
          end
        end
        S_RUN: begin
          shreg <= shreg_next;
          rem   <= rem_next;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            quotient_r  <= shreg_next;
            remainder_r <= rem_next;
            dbz_r       <= 1'b0;
            state       <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider_8x4.sv
// tb/tb_seq_divider_8x4.sv - self-checking bench for seq_divider_8x4
module tb_seq_divider_8x4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  seq_divider_8x4_if dif ();

  seq_divider_8x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division; divide-by-zero returns all-ones with the flag.
  task automatic model(input logic [7:0] a, input logic [3:0] b,
                       output logic [7:0] q, output logic [3:0] r, output logic z);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      q = 8'hFF; r = 4'hF; z = 1'b1;
    end else begin
      q = 8'(ai / bi); r = 4'(ai % bi); z = 1'b0;
    end
  endtask

  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] qe, input logic [3:0] re, input logic ze,
                         input string tag);
    int lat, bcnt, both;
    lat = 0; bcnt = 0; both = 0;
    dif.start = 1'b1; dif.dividend = a; dif.divisor = b;
    @(posedge clk); #1;
    dif.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      dif.dividend = 8'($urandom);
      dif.divisor  = 4'($urandom);
      if (dif.busy) bcnt++;
      if (dif.busy && dif.done) both++;
      if (dif.done) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, (b == 4'd0) ? 1 : 9);
    check({tag, " busy_cycles"}, bcnt, (b == 4'd0) ? 0 : 8);
    check({tag, " busy_and_done"}, both, 0);
    check({tag, " quotient"}, dif.quotient, qe);
    check({tag, " remainder"}, dif.remainder, re);
    check({tag, " div_by_zero"}, dif.div_by_zero, ze);
    @(posedge clk); #1;
    check({tag, " done_single"}, dif.done, 0);
    check({tag, " quotient_held"}, dif.quotient, qe);
  endtask

  initial begin
    logic [7:0] qe;
    logic [3:0] re;
    logic       ze;
    int         dones;

    vecs[0] = '{a: 8'd143, b: 4'd11, q: 8'd13,  r: 4'd0, z: 1'b0};
    vecs[1] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4, z: 1'b0};
    vecs[2] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, z: 1'b0};
    vecs[3] = '{a: 8'd225, b: 4'd15, q: 8'd15,  r: 4'd0, z: 1'b0};
    vecs[4] = '{a: 8'd5,   b: 4'd9,  q: 8'd0,   r: 4'd5, z: 1'b0};
    vecs[5] = '{a: 8'd0,   b: 4'd3,  q: 8'd0,   r: 4'd0, z: 1'b0};
    vecs[6] = '{a: 8'd77,  b: 4'd0,  q: 8'hFF,  r: 4'hF, z: 1'b1};
    vecs[7] = '{a: 8'd77,  b: 4'd7,  q: 8'd11,  r: 4'd0, z: 1'b0};

    dif.start = 1'b0; dif.dividend = 8'd0; dif.divisor = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", dif.busy, 0);
    check("reset done", dif.done, 0);
    check("reset quotient", dif.quotient, 0);
    check("reset remainder", dif.remainder, 0);
    check("reset div_by_zero", dif.div_by_zero, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, $sformatf("vec%0d", i));

    // Start ignored during RUN while operands churn every cycle.
    dones = 0;
    dif.start = 1'b1; dif.dividend = 8'd100; dif.divisor = 4'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      dif.start    = (k >= 2 && k <= 7) ? 1'b1 : 1'b0;
      dif.dividend = (k % 2 == 0) ? 8'd50 : 8'($urandom);
      dif.divisor  = (k % 2 == 0) ? 4'd5 : 4'($urandom_range(15, 1));
      @(posedge clk); #1;
      if (dif.done) begin
        dones++;
        check("ignore latency", k, 9);
        check("ignore quotient", dif.quotient, 33);
        check("ignore remainder", dif.remainder, 1);
      end
    end
    dif.start = 1'b0;
    check("ignore done_count", dones, 1);

    // Asynchronous reset mid-RUN.
    dif.start = 1'b1; dif.dividend = 8'd250; dif.divisor = 4'd6;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrun busy_before", dif.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrun busy", dif.busy, 0);
    check("midrun done", dif.done, 0);
    check("midrun quotient", dif.quotient, 0);
    check("midrun remainder", dif.remainder, 0);
    check("midrun div_by_zero", dif.div_by_zero, 0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (dif.done) dones++;
    end
    check("midrun no_done", dones, 0);
    rst_n = 1'b1;
    run_div(8'd250, 4'd6, 8'd41, 4'd4, 1'b0, "after_reset");

    // Start held high: one accept every 10 cycles.
    dif.start = 1'b1; dif.dividend = 8'd60; dif.divisor = 4'd4;
    @(posedge clk); #1;
    for (int k = 1; k <= 39; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold done k%0d", k), dif.done, (k % 10 == 9) ? 1 : 0);
      check($sformatf("hold busy k%0d", k), dif.busy, (k % 10 >= 1 && k % 10 <= 8) ? 1 : 0);
      if (k >= 9) begin
        check($sformatf("hold quotient k%0d", k), dif.quotient, 15);
        check($sformatf("hold remainder k%0d", k), dif.remainder, 0);
      end
    end
    dif.start = 1'b0;
    @(posedge clk); #1;

    // Exhaustive sweep of nonzero divisors.
    for (int b = 1; b < 16; b++) begin
      for (int a = 0; a < 256; a++) begin
        model(8'(a), 4'(b), qe, re, ze);
        total++;
        if ((int'(qe) * b + int'(re) != a) || (int'(re) >= b)) begin
          bad++;
          $display("FAIL model_identity: a=%0d b=%0d q=%0d r=%0d", a, b, qe, re);
        end
        run_div(8'(a), 4'(b), qe, re, ze, $sformatf("sweep %0d/%0d", a, b));
      end
    end

    // Random operands including zero divisors.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] a;
      logic [3:0] b;
      a = 8'($urandom);
      b = ($urandom_range(7, 0) == 0) ? 4'd0 : 4'($urandom);
      model(a, b, qe, re, ze);
      run_div(a, b, qe, re, ze, $sformatf("rand %0d/%0d", a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
